// File: rtl/op_unit_pipelined_if.sv
// Handshake bundle for op_unit_pipelined: operand/op request channel and result channel.
// out_parity exists only when OP_UNIT_PARITY_EN is defined.
interface op_unit_pipelined_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_data;
    logic             out_err;
`ifdef OP_UNIT_PARITY_EN
    logic             out_parity;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_parity
    );
    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err, out_parity
    );
`else
    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
`endif
endinterface

// File: rtl/op_unit_pipelined.sv
// Op-select unit: PASS/ADD/DBL in one cycle, POP/CLZ iterated BITS_PER_CYCLE bits per cycle.
// Optional registered out_parity when OP_UNIT_PARITY_EN is defined.
module op_unit_pipelined #(
    parameter int WIDTH          = 8,
    parameter int ADD_CONST      = 2,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic               clock,
    input logic               reset_n,
    op_unit_pipelined_if.slave bus
);
    localparam int K  = (WIDTH + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(K + 1);
    localparam logic [WIDTH-1:0] ADD_K = WIDTH'(ADD_CONST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic             is_clz_r, is_clz_s;
    logic             seen_r, seen_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [WIDTH:0]   out_data_r, out_data_s;
    logic             out_err_r, out_err_s;
    logic             out_valid_r;
    logic             in_ready_s;
    logic             accept_s;

    function automatic logic [WIDTH:0] single_op_f(input logic [2:0] op, input logic [WIDTH-1:0] d);
        case (op)
            3'b000:  return {1'b0, d};
            3'b001:  return {1'b0, d} + {1'b0, ADD_K};
            3'b010:  return {d, 1'b0};
            default: return {(WIDTH+1){1'b0}};
        endcase
    endfunction

`ifdef OP_UNIT_PARITY_EN
    logic out_parity_r;

    function automatic logic parity_f(input logic [WIDTH:0] v);
        return ^v;
    endfunction
`endif

    // Next-state and datapath update; DONE hands straight over to a new accept
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        is_clz_s   = is_clz_r;
        seen_s     = seen_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        out_data_s = out_data_r;
        out_err_s  = out_err_r;
        in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
        accept_s   = bus.in_valid && in_ready_s;

        case (state_r)
            IDLE: state_s = IDLE;
            BUSY: begin
                // Bits past the LSB in a final partial chunk are skipped
                for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                    if ((int'(idx_r) * BITS_PER_CYCLE + j) < WIDTH) begin
                        if (is_clz_r) begin
                            cnt_s  = cnt_s + CW'(!seen_s && !shift_r[WIDTH-1-j]);
                            seen_s = seen_s | shift_r[WIDTH-1-j];
                        end else begin
                            cnt_s  = cnt_s + CW'(shift_r[WIDTH-1-j]);
                        end
                    end else begin
                        cnt_s = cnt_s;
                    end
                end
                shift_s = shift_r << BITS_PER_CYCLE;
                if (idx_r == IW'(K - 1)) begin
                    out_data_s = {{(WIDTH+1-CW){1'b0}}, cnt_s};
                    out_err_s  = 1'b0;
                    state_s    = DONE;
                end else begin
                    idx_s = idx_r + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase

        if (accept_s) begin
            case (bus.in_op)
                3'b011, 3'b100: begin
                    state_s  = BUSY;
                    shift_s  = bus.in_data;
                    is_clz_s = (bus.in_op == 3'b100);
                    seen_s   = 1'b0;
                    cnt_s    = {CW{1'b0}};
                    idx_s    = {IW{1'b0}};
                end
                default: begin
                    state_s    = DONE;
                    out_data_s = single_op_f(bus.in_op, bus.in_data);
                    out_err_s  = (bus.in_op >= 3'b101);
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_r     <= {WIDTH{1'b0}};
            is_clz_r    <= 1'b0;
            seen_r      <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= {IW{1'b0}};
            out_data_r  <= {(WIDTH+1){1'b0}};
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            shift_r     <= shift_s;
            is_clz_r    <= is_clz_s;
            seen_r      <= seen_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            out_data_r  <= out_data_s;
            out_err_r   <= out_err_s;
            out_valid_r <= (state_s == DONE);
        end
    end

`ifdef OP_UNIT_PARITY_EN
    // Parity tracks out_data so it is held under backpressure too
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_parity_r <= 1'b0;
        end else begin
            out_parity_r <= parity_f(out_data_s);
        end
    end

    assign bus.out_parity = out_parity_r;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_op_unit_pipelined.sv
// Directed bench for op_unit_pipelined: dut0 iterates 1 bit/cycle, dut1 3 bits/cycle,
// both fed the same stimulus.
module tb_op_unit_pipelined;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clock = ~clock;

    op_unit_pipelined_if #(.WIDTH(8)) bus0 ();
    op_unit_pipelined_if #(.WIDTH(8)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_data   = bus0.in_data;
    assign bus1.in_op     = bus0.in_op;
    assign bus1.out_ready = bus0.out_ready;

    op_unit_pipelined #(.WIDTH(8), .ADD_CONST(2), .BITS_PER_CYCLE(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0)
    );
    op_unit_pipelined #(.WIDTH(8), .ADD_CONST(2), .BITS_PER_CYCLE(3)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [7:0] d);
        bus0.in_valid = 1'b1;
        bus0.in_op    = op;
        bus0.in_data  = d;
        cyc();
        bus0.in_valid = 1'b0;
        bus0.in_op    = 3'bxxx;
        bus0.in_data  = 8'hxx;
    endtask

    task automatic test_reset();
        bus0.in_valid  = 1'b0;
        bus0.in_op     = 3'b000;
        bus0.in_data   = 8'h00;
        bus0.out_ready = 1'b1;
        #1 reset_n = 1'b0;
        cyc();
        cyc();
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", bus0.out_valid); end
        checks++; if (bus0.out_data !== 9'h000) begin errors++; $display("FAIL reset out_data got %h want 000", bus0.out_data); end
        checks++; if (bus0.out_err !== 1'b0) begin errors++; $display("FAIL reset out_err got %b want 0", bus0.out_err); end
        reset_n = 1'b1;
        cyc();
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", bus0.in_ready); end
    endtask

    task automatic test_single();
        logic [2:0] ops [3] = '{3'b001, 3'b010, 3'b000};
        logic [7:0] din [3] = '{8'hFF, 8'h80, 8'h5A};
        logic [8:0] exp [3] = '{9'h101, 9'h100, 9'h05A};
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], din[i]);
            checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL single[%0d] out_valid got %b want 1", i, bus0.out_valid); end
            checks++; if (bus0.out_data !== exp[i]) begin errors++; $display("FAIL single[%0d] out_data got %h want %h", i, bus0.out_data, exp[i]); end
            checks++; if (bus0.out_err !== 1'b0) begin errors++; $display("FAIL single[%0d] out_err got %b want 0", i, bus0.out_err); end
`ifdef OP_UNIT_PARITY_EN
            checks++; if (bus0.out_parity !== ^exp[i]) begin errors++; $display("FAIL single[%0d] out_parity got %b want %b", i, bus0.out_parity, ^exp[i]); end
`endif
            cyc();
            checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL single[%0d] out_valid drop got %b want 0", i, bus0.out_valid); end
        end
    endtask

    task automatic test_reserved();
        drive_op(3'b110, 8'hFF);
        checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL reserved out_valid got %b want 1", bus0.out_valid); end
        checks++; if (bus0.out_data !== 9'h000) begin errors++; $display("FAIL reserved out_data got %h want 000", bus0.out_data); end
        checks++; if (bus0.out_err !== 1'b1) begin errors++; $display("FAIL reserved out_err got %b want 1", bus0.out_err); end
        cyc();
        drive_op(3'b000, 8'h3C);
        checks++; if (bus0.out_data !== 9'h03C) begin errors++; $display("FAIL after_reserved out_data got %h want 03C", bus0.out_data); end
        checks++; if (bus0.out_err !== 1'b0) begin errors++; $display("FAIL after_reserved out_err got %b want 0", bus0.out_err); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b010, 3'b001};
        logic [7:0] din [4] = '{8'h12, 8'h7F, 8'h41, 8'h00};
        logic [8:0] exp [4] = '{9'h012, 9'h081, 9'h082, 9'h002};
        for (int i = 0; i < 4; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_op    = ops[i];
            bus0.in_data  = din[i];
            checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] in_ready got %b want 1", i, bus0.in_ready); end
            cyc();
            checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d] out_valid got %b want 1", i, bus0.out_valid); end
            checks++; if (bus0.out_data !== exp[i]) begin errors++; $display("FAIL b2b[%0d] out_data got %h want %h", i, bus0.out_data, exp[i]); end
        end
        bus0.in_valid = 1'b0;
        cyc();
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b end out_valid got %b want 0", bus0.out_valid); end
    endtask

    // Iterative op scenario: latency 9 at 1 bit/cycle, 4 at 3 bits/cycle
    task automatic run_iter(input logic [2:0] op, input logic [7:0] d, input logic [8:0] exp, input string name);
        int         lat0 = 0;
        int         lat1 = 0;
        logic [8:0] d0 = 9'h000;
        logic [8:0] d1 = 9'h000;
        bit         rdy_bad = 1'b0;
        drive_op(op, d);
        for (int n = 1; n <= 30; n++) begin
            if (bus1.out_valid && lat1 == 0) begin lat1 = n; d1 = bus1.out_data; end
            if (bus0.out_valid && lat0 == 0) begin lat0 = n; d0 = bus0.out_data; end
            if (lat0 == 0 && bus0.in_ready) rdy_bad = 1'b1;
            if (lat0 != 0 && lat1 != 0) break;
            cyc();
        end
        checks++; if (lat0 !== 9) begin errors++; $display("FAIL %s latency bpc1 got %0d want 9", name, lat0); end
        checks++; if (lat1 !== 4) begin errors++; $display("FAIL %s latency bpc3 got %0d want 4", name, lat1); end
        checks++; if (d0 !== exp) begin errors++; $display("FAIL %s out_data bpc1 got %h want %h", name, d0, exp); end
        checks++; if (d1 !== exp) begin errors++; $display("FAIL %s out_data bpc3 got %h want %h", name, d1, exp); end
        checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL %s in_ready while busy got 1 want 0", name); end
        checks++; if (bus0.out_err !== 1'b0) begin errors++; $display("FAIL %s out_err got %b want 0", name, bus0.out_err); end
        cyc();
    endtask

    task automatic test_pop();
        run_iter(3'b011, 8'hB5, 9'd5, "pop_b5");
    endtask

    task automatic test_clz();
        run_iter(3'b100, 8'h10, 9'd3, "clz_10");
        run_iter(3'b100, 8'h00, 9'd8, "clz_00");
        run_iter(3'b100, 8'h80, 9'd0, "clz_80");
    endtask

    task automatic test_backpressure();
        bus0.out_ready = 1'b0;
        drive_op(3'b001, 8'h10);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] out_valid got %b want 1", i, bus0.out_valid); end
            checks++; if (bus0.out_data !== 9'h012) begin errors++; $display("FAIL bp[%0d] out_data got %h want 012", i, bus0.out_data); end
            checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] in_ready got %b want 0", i, bus0.in_ready); end
            cyc();
        end
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.in_op     = 3'b010;
        bus0.in_data   = 8'h21;
        #1;
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL bp handoff in_ready got %b want 1", bus0.in_ready); end
        cyc();
        bus0.in_valid = 1'b0;
        checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL bp handoff out_valid got %b want 1", bus0.out_valid); end
        checks++; if (bus0.out_data !== 9'h042) begin errors++; $display("FAIL bp handoff out_data got %h want 042", bus0.out_data); end
        cyc();
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL bp end out_valid got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_reset_mid_busy();
        bit spurious = 1'b0;
        drive_op(3'b011, 8'hB5);
        cyc();
        cyc();
        checks++; if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_busy in_ready before got %b want 0", bus0.in_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy out_valid got %b want 0", bus0.out_valid); end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy out_valid bpc3 got %b want 0", bus1.out_valid); end
        cyc();
        reset_n = 1'b1;
        checks++; if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy in_ready after got %b want 1", bus0.in_ready); end
        for (int i = 0; i < 12; i++) begin
            if (bus0.out_valid || bus1.out_valid) spurious = 1'b1;
            cyc();
        end
        checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL rst_busy stale result got 1 want 0"); end
        drive_op(3'b001, 8'h40);
        checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL rst_busy next out_valid got %b want 1", bus0.out_valid); end
        checks++; if (bus0.out_data !== 9'h042) begin errors++; $display("FAIL rst_busy next out_data got %h want 042", bus0.out_data); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_reserved();
        test_back_to_back();
        test_pop();
        test_clz();
        test_backpressure();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
